// File: rtl/can_rx_pkg.sv
// Shared CAN receive-path types: message width and message type used by the
// acceptance filter and the receive FIFO.
package can_rx_pkg;

  localparam int CAN_MSG_W = 128;

  typedef logic [CAN_MSG_W-1:0] can_msg_t;

endpackage

// File: rtl/can_rx_fifo_mem.sv
// Message storage for the CAN receive FIFO: register array with one write
// port and one asynchronous read port. Contents are never reset.
module can_rx_fifo_mem
  import can_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = CAN_MSG_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/can_rx_fifo.sv
// CAN receive message FIFO between the acceptance filter (writer) and the
// host read side: show-ahead head, fill count, watermark, sticky error flags.
module can_rx_fifo
  import can_rx_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MSG_W     = CAN_MSG_W,
  parameter int AF_THRESH = 12
) (
  input  logic                       i_rxf_sys_clk,
  input  logic                       i_rxf_reset,
  input  logic                       i_rxf_w_en,
  input  logic [MSG_W-1:0]           i_rxf_w_data,
  output logic                       o_rxf_full,
  input  logic                       i_rxf_r_en,
  output logic [MSG_W-1:0]           o_rxf_r_data,
  output logic                       o_rxf_empty,
  output logic [$clog2(DEPTH):0]     o_rxf_count,
  output logic                       o_rxf_almost_full,
  input  logic                       i_rxf_err_clr,
  output logic                       o_rxf_overflow,
  output logic                       o_rxf_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: w_en and r_en are single-cycle strobes with no back-pressure.
  // A strobe is accepted only if the count registered at the start of the
  // cycle allows it (write: count<DEPTH, pop: count>0); a refused strobe is
  // discarded and recorded in the matching sticky error flag. A pop in the
  // same cycle never frees space for a write.
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;

  logic             wr_acc;
  logic             rd_acc;
  logic [MSG_W-1:0] mem_rdata;

  assign wr_acc = i_rxf_w_en && (count_q != CW'(DEPTH));
  assign rd_acc = i_rxf_r_en && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new error event wins over a clear in the same cycle.
    if (i_rxf_w_en && !wr_acc)  ovf_d = 1'b1;
    else if (i_rxf_err_clr)     ovf_d = 1'b0;

    if (i_rxf_r_en && !rd_acc)  udf_d = 1'b1;
    else if (i_rxf_err_clr)     udf_d = 1'b0;
  end

  always_ff @(posedge i_rxf_sys_clk) begin
    if (i_rxf_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Reset gates the write so a strobe in the reset cycle is never stored.
  can_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (MSG_W),
    .AW    (AW)
  ) u_mem (
    .clk_i   (i_rxf_sys_clk),
    .we_i    (wr_acc && !i_rxf_reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_rxf_w_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign o_rxf_r_data      = (count_q != '0) ? mem_rdata : '0;
  assign o_rxf_empty       = (count_q == '0);
  assign o_rxf_full        = (count_q == CW'(DEPTH));
  assign o_rxf_almost_full = (count_q >= CW'(AF_THRESH));
  assign o_rxf_count       = count_q;
  assign o_rxf_overflow    = ovf_q;
  assign o_rxf_underflow   = udf_q;

endmodule

// File: tb/tb_can_rx_fifo.sv
// Self-checking bench for can_rx_fifo (DEPTH=4, AF_THRESH=3) with a
// scoreboard queue of expected messages.
module tb_can_rx_fifo;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int W     = 128;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_en;
  logic [W-1:0]  w_data;
  logic          full;
  logic          r_en;
  logic [W-1:0]  r_data;
  logic          empty;
  logic [CW-1:0] count;
  logic          af;
  logic          err_clr;
  logic          ovf;
  logic          udf;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  can_rx_fifo #(
    .DEPTH     (DEPTH),
    .MSG_W     (W),
    .AF_THRESH (AF)
  ) dut (
    .i_rxf_sys_clk     (clk),
    .i_rxf_reset       (rst),
    .i_rxf_w_en        (w_en),
    .i_rxf_w_data      (w_data),
    .o_rxf_full        (full),
    .i_rxf_r_en        (r_en),
    .o_rxf_r_data      (r_data),
    .o_rxf_empty       (empty),
    .o_rxf_count       (count),
    .o_rxf_almost_full (af),
    .i_rxf_err_clr     (err_clr),
    .o_rxf_overflow    (ovf),
    .o_rxf_underflow   (udf)
  );

  // clock / reset
  always #5 clk = ~clk;

  // one clock edge; outputs are sampled 1ns after it, inputs change there too
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [3:0] hi, input logic [3:0] lo);
    return {{31{hi}}, lo};
  endfunction

  function automatic logic [W-1:0] rnd_msg();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // driver: single write strobe; scoreboard records it only if there is room
  task automatic drv_write(input logic [W-1:0] d);
    w_en   = 1'b1;
    w_data = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    cyc();
    w_en = 1'b0;
  endtask

  // driver: pop with the head compared against the scoreboard before the edge
  task automatic drv_pop(input string name);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    total++;
    if (r_data !== e) begin
      bad++;
      $display("FAIL %s head: got %h expected %h", name, r_data, e);
    end
    r_en = 1'b1;
    cyc();
    r_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; w_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    exp_q.delete();
    total++;
    if ({empty, full, af, ovf, udf} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags: got %b expected 10000", {empty, full, af, ovf, udf});
    end
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d expected 0", count);
    end
    total++;
    if (r_data !== '0) begin
      bad++;
      $display("FAIL reset_rdata: got %h expected 0", r_data);
    end
  endtask

  task automatic test_fill_drain();
    drv_write(mk(4'hA, 4'h1));
    total++;
    if (empty !== 1'b0 || count !== 3'd1 || r_data !== mk(4'hA, 4'h1)) begin
      bad++;
      $display("FAIL first_write: got empty=%b count=%0d data=%h expected 0/1/%h",
               empty, count, r_data, mk(4'hA, 4'h1));
    end
    drv_write(mk(4'hB, 4'h2));
    total++;
    if (af !== 1'b0) begin
      bad++;
      $display("FAIL af_at_2: got %b expected 0", af);
    end
    drv_write(mk(4'hC, 4'h3));
    total++;
    if (af !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL af_at_3: got af=%b full=%b expected af=1 full=0", af, full);
    end
    drv_write(mk(4'hD, 4'h4));
    total++;
    if (full !== 1'b1 || count !== 3'd4) begin
      bad++;
      $display("FAIL full_at_4: got full=%b count=%0d expected 1/4", full, count);
    end
    for (int i = 0; i < 4; i++) drv_pop("fill_drain");
    total++;
    if (empty !== 1'b1 || r_data !== '0) begin
      bad++;
      $display("FAIL drained: got empty=%b data=%h expected 1/0", empty, r_data);
    end
  endtask

  task automatic test_overflow();
    drv_write(mk(4'hA, 4'h1));
    drv_write(mk(4'hB, 4'h2));
    drv_write(mk(4'hC, 4'h3));
    drv_write(mk(4'hD, 4'h4));
    // write while full together with a pop: write dropped, pop taken
    w_en = 1'b1; w_data = {W/8{8'hEE}}; r_en = 1'b1;
    void'(exp_q.pop_front());
    cyc();
    w_en = 1'b0; r_en = 1'b0;
    total++;
    if (ovf !== 1'b1 || count !== 3'd3) begin
      bad++;
      $display("FAIL ovf_set: got ovf=%b count=%0d expected 1/3", ovf, count);
    end
    total++;
    if (r_data !== mk(4'hB, 4'h2)) begin
      bad++;
      $display("FAIL ovf_head: got %h expected %h", r_data, mk(4'hB, 4'h2));
    end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got %b expected 0", ovf);
    end
    while (exp_q.size() > 0) drv_pop("ovf_drain");
  endtask

  task automatic test_underflow();
    r_en = 1'b1;
    cyc();
    r_en = 1'b0;
    total++;
    if (udf !== 1'b1 || count !== 3'd0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL udf_set: got udf=%b count=%0d empty=%b expected 1/0/1", udf, count, empty);
    end
    r_en = 1'b1; err_clr = 1'b1;
    cyc();
    r_en = 1'b0; err_clr = 1'b0;
    total++;
    if (udf !== 1'b1) begin
      bad++;
      $display("FAIL udf_set_beats_clr: got %b expected 1", udf);
    end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    total++;
    if (udf !== 1'b0) begin
      bad++;
      $display("FAIL udf_clear: got %b expected 0", udf);
    end
    // pointers must not have moved: a fresh write is the head
    drv_write(mk(4'h5, 4'h6));
    drv_pop("udf_ptrs");
  endtask

  task automatic test_simul_wrap();
    logic [W-1:0] d;
    drv_write(rnd_msg());
    drv_write(rnd_msg());
    for (int i = 0; i < 10; i++) begin
      d = rnd_msg();
      exp_q.push_back(d);
      w_en = 1'b1; w_data = d;
      drv_pop("simul_head");
      w_en = 1'b0;
      total++;
      if (count !== 3'd2) begin
        bad++;
        $display("FAIL simul_count: iter %0d got %0d expected 2", i, count);
      end
    end
    while (exp_q.size() > 0) drv_pop("simul_drain");
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) drv_write(rnd_msg());
    rst = 1'b1; w_en = 1'b1; w_data = {W/8{8'h77}};
    cyc();
    rst = 1'b0; w_en = 1'b0;
    exp_q.delete();
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || r_data !== '0) begin
      bad++;
      $display("FAIL rst_mid: got count=%0d empty=%b data=%h expected 0/1/0", count, empty, r_data);
    end
    drv_write(mk(4'h9, 4'h8));
    total++;
    if (count !== 3'd1) begin
      bad++;
      $display("FAIL rst_mid_refill: got count=%0d expected 1", count);
    end
    drv_pop("rst_mid_head");
  endtask

  task automatic test_back_to_back();
    logic ovf_m, udf_m, wa, ra, cl, wr, rd;
    logic [W-1:0] d, e_head;
    ovf_m = 1'b0; udf_m = 1'b0;
    for (int c = 0; c < 300; c++) begin
      wr = ($urandom_range(0, 99) < 65);
      rd = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 9) == 0);
      d  = rnd_msg();
      wa = wr && (exp_q.size() < DEPTH);
      ra = rd && (exp_q.size() > 0);
      if (ra) void'(exp_q.pop_front());
      if (wa) exp_q.push_back(d);
      if (wr && !wa) ovf_m = 1'b1; else if (cl) ovf_m = 1'b0;
      if (rd && !ra) udf_m = 1'b1; else if (cl) udf_m = 1'b0;
      w_en = wr; w_data = d; r_en = rd; err_clr = cl;
      cyc();
      w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
      e_head = (exp_q.size() > 0) ? exp_q[0] : '0;
      total++;
      if (count !== CW'(exp_q.size())) begin
        bad++;
        $display("FAIL b2b_count: cyc %0d got %0d expected %0d", c, count, exp_q.size());
      end
      total++;
      if (r_data !== e_head) begin
        bad++;
        $display("FAIL b2b_head: cyc %0d got %h expected %h", c, r_data, e_head);
      end
      total++;
      if ({full, empty, af, ovf, udf} !==
          {exp_q.size() == DEPTH, exp_q.size() == 0, exp_q.size() >= AF, ovf_m, udf_m}) begin
        bad++;
        $display("FAIL b2b_flags: cyc %0d got %b expected %b", c, {full, empty, af, ovf, udf},
                 {exp_q.size() == DEPTH, exp_q.size() == 0, exp_q.size() >= AF, ovf_m, udf_m});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simul_wrap();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
